jtvigil_snd_romarb: RTL and testbench

- Shares the single sound ROM port between two requesters: sound Z80 opcode/data fetches and the PCM sample fetch path.
- Sits between the sound CPU and PCM controller on one side and the SDRAM ROM slot on the other.
- Arbitrates round-robin and keeps a one-byte cache per requester.
- Optionally prefetches the next PCM byte so a sample advance does not wait on SDRAM.

---
 rtl/jtvigil_snd_pkg.sv | 29 ++
 rtl/jtvigil_snd_romarb_entry.sv | 49 ++++
 rtl/jtvigil_snd_romarb.sv | 168 ++++++++++++++++
 tb/tb_jtvigil_snd_romarb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtvigil_snd_pkg.sv
// Shared types and constants for the sound ROM arbiter: bus widths, FSM states,
// grant IDs and the PCM window base on the shared ROM bus.
package jtvigil_snd_pkg;

    localparam int unsigned AW = 16;
    localparam int unsigned BW = 17;
    localparam int unsigned DW = 8;

    localparam logic [BW-1:0] PCM_BASE_DEF = 17'h10000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_BUS = 2'd1,
        ST_PCM_BUS = 2'd2,
        ST_PRE_BUS = 2'd3
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_PCM = 1'b1
    } grant_e;

    // Requester address mapped into the PCM window; the carry out of bit 16 is dropped.
    function automatic logic [BW-1:0] pcm_bus_addr(input logic [BW-1:0] base,
                                                   input logic [AW-1:0] addr);
        return base + BW'(addr);
    endfunction

endpackage

// File: rtl/jtvigil_snd_romarb_entry.sv
// One-byte cache entry: valid/tag/data register with a combinational tag compare.
// A fill takes priority over a load, and a load takes priority over a clear.
module jtvigil_snd_romarb_entry
    import jtvigil_snd_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          fill_i,
    input  logic [15:0]   fill_tag_i,
    input  logic [7:0]    fill_data_i,
    input  logic          load_i,
    input  logic [15:0]   load_tag_i,
    input  logic [7:0]    load_data_i,
    input  logic          clear_i,
    input  logic [15:0]   cmp_addr_i,
    output logic          valid_o,
    output logic [15:0]   tag_o,
    output logic [7:0]    data_o,
    output logic          hit_c_o
);

    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
        end else if (load_i) begin
            valid_q <= 1'b1;
            tag_q   <= load_tag_i;
            data_q  <= load_data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign data_o  = data_q;
    assign hit_c_o = valid_q && (tag_q == cmp_addr_i);

endmodule

// File: rtl/jtvigil_snd_romarb.sv
// Round-robin arbiter sharing the sound ROM slot between the Z80 and the PCM fetcher,
// with a one-byte cache per requester and an optional next-byte PCM prefetch entry.
module jtvigil_snd_romarb
    import jtvigil_snd_pkg::*;
#(
    parameter logic [16:0] PCM_BASE = PCM_BASE_DEF,
    parameter int unsigned PREFETCH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_cs,
    input  logic [15:0] cpu_addr,
    output logic [7:0]  cpu_data,
    output logic        cpu_ok,
    input  logic        pcm_cs,
    input  logic [15:0] pcm_addr,
    output logic [7:0]  pcm_data,
    output logic        pcm_ok,
    output logic        rom_cs,
    output logic [16:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok
);

    state_e        state_q;
    grant_e        last_grant_q;
    logic          rom_cs_q;
    logic [BW-1:0] rom_addr_q;
    logic          armed_q;
    logic [AW-1:0] cap_tag_q;

    logic          c_valid, p_valid, n_valid;
    logic [AW-1:0] c_tag, p_tag, n_tag;
    logic [DW-1:0] c_data, p_data, n_data;
    logic          c_hit_raw, p_hit_raw, n_hit_raw;

    logic          p_hit, n_hit, cpu_miss, pcm_miss;
    logic          fill_ok, fill_c, fill_p, fill_n, promote;
    logic [AW-1:0] p_next;
    logic          pre_want;

    logic          gnt_valid_d;
    state_e        gnt_state_d;
    grant_e        gnt_who_d;
    logic [BW-1:0] gnt_addr_d;
    logic [AW-1:0] gnt_tag_d;

    // Hit side: combinational against the registered entries.
    assign cpu_ok   = cpu_cs & c_hit_raw;
    assign cpu_data = c_data;
    assign p_hit    = pcm_cs & p_hit_raw;
    assign n_hit    = pcm_cs & n_hit_raw;
    assign pcm_ok   = p_hit | n_hit;
    assign pcm_data = (n_hit && !p_hit) ? n_data : p_data;

    assign cpu_miss = cpu_cs & ~cpu_ok;
    assign pcm_miss = pcm_cs & ~pcm_ok;

    assign fill_ok  = armed_q & rom_ok & (state_q != ST_IDLE);
    assign fill_c   = fill_ok & (state_q == ST_CPU_BUS);
    assign fill_p   = fill_ok & (state_q == ST_PCM_BUS);
    assign fill_n   = fill_ok & (state_q == ST_PRE_BUS);
    // A fill landing in P or N the same cycle cancels the N->P promotion.
    assign promote  = n_hit & ~p_hit & ~fill_p & ~fill_n;

    assign p_next   = p_tag + 16'd1;
    assign pre_want = (PREFETCH != 0) && pcm_cs && p_valid
                      && !(n_valid && (n_tag == p_next)) && (p_tag != 16'hFFFF);

    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;

    jtvigil_snd_romarb_entry u_c (
        .clk(clk), .rst(rst),
        .fill_i(fill_c), .fill_tag_i(cap_tag_q), .fill_data_i(rom_data),
        .load_i(1'b0), .load_tag_i(16'h0000), .load_data_i(8'h00),
        .clear_i(1'b0), .cmp_addr_i(cpu_addr),
        .valid_o(c_valid), .tag_o(c_tag), .data_o(c_data), .hit_c_o(c_hit_raw)
    );

    jtvigil_snd_romarb_entry u_p (
        .clk(clk), .rst(rst),
        .fill_i(fill_p), .fill_tag_i(cap_tag_q), .fill_data_i(rom_data),
        .load_i(promote), .load_tag_i(n_tag), .load_data_i(n_data),
        .clear_i(1'b0), .cmp_addr_i(pcm_addr),
        .valid_o(p_valid), .tag_o(p_tag), .data_o(p_data), .hit_c_o(p_hit_raw)
    );

    generate
        if (PREFETCH != 0) begin : g_pre
            jtvigil_snd_romarb_entry u_n (
                .clk(clk), .rst(rst),
                .fill_i(fill_n), .fill_tag_i(cap_tag_q), .fill_data_i(rom_data),
                .load_i(1'b0), .load_tag_i(16'h0000), .load_data_i(8'h00),
                .clear_i(promote), .cmp_addr_i(pcm_addr),
                .valid_o(n_valid), .tag_o(n_tag), .data_o(n_data), .hit_c_o(n_hit_raw)
            );
        end else begin : g_nopre
            assign n_valid   = 1'b0;
            assign n_tag     = '0;
            assign n_data    = '0;
            assign n_hit_raw = 1'b0;
        end
    endgenerate

    // Grant selection while idle: demand misses round-robin, prefetch only when no miss.
    always_comb begin
        gnt_valid_d = 1'b0;
        gnt_state_d = ST_IDLE;
        gnt_who_d   = last_grant_q;
        gnt_addr_d  = rom_addr_q;
        gnt_tag_d   = cap_tag_q;
        if (cpu_miss && (!pcm_miss || last_grant_q == GNT_PCM)) begin
            gnt_valid_d = 1'b1;
            gnt_state_d = ST_CPU_BUS;
            gnt_who_d   = GNT_CPU;
            gnt_addr_d  = {1'b0, cpu_addr};
            gnt_tag_d   = cpu_addr;
        end else if (pcm_miss) begin
            gnt_valid_d = 1'b1;
            gnt_state_d = ST_PCM_BUS;
            gnt_who_d   = GNT_PCM;
            gnt_addr_d  = pcm_bus_addr(PCM_BASE, pcm_addr);
            gnt_tag_d   = pcm_addr;
        end else if (pre_want) begin
            gnt_valid_d = 1'b1;
            gnt_state_d = ST_PRE_BUS;
            gnt_who_d   = GNT_PCM;
            gnt_addr_d  = pcm_bus_addr(PCM_BASE, p_next);
            gnt_tag_d   = p_next;
        end
    end

    // Bus FSM: rom_ok is armed from the second cycle of rom_cs; the return to idle
    // leaves rom_cs low for at least one cycle before the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_PCM;
            rom_cs_q     <= 1'b0;
            rom_addr_q   <= '0;
            armed_q      <= 1'b0;
            cap_tag_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    armed_q <= 1'b0;
                    if (gnt_valid_d) begin
                        state_q      <= gnt_state_d;
                        last_grant_q <= gnt_who_d;
                        rom_cs_q     <= 1'b1;
                        rom_addr_q   <= gnt_addr_d;
                        cap_tag_q    <= gnt_tag_d;
                    end
                end
                default: begin
                    armed_q <= 1'b1;
                    if (fill_ok) begin
                        state_q  <= ST_IDLE;
                        rom_cs_q <= 1'b0;
                        armed_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtvigil_snd_romarb.sv
// Directed and randomized bench for jtvigil_snd_romarb against a transaction-level
// model of the caches, the round-robin grant and the shared-bus handshake.
module tb_jtvigil_snd_romarb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_cs = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_data;
    logic        cpu_ok;
    logic        pcm_cs = 1'b0;
    logic [15:0] pcm_addr = 16'h0;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic        rom_cs;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtvigil_snd_romarb dut (
        .clk(clk), .rst(rst),
        .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
        .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok)
    );

    // ROM contents: a fixed scramble of the bus address.
    function automatic logic [7:0] rom_f(input logic [16:0] a);
        return a[7:0] ^ {a[16:13], a[11:8]} ^ 8'h5A;
    endfunction

    assign rom_data = rom_f(rom_addr);

    // Model: entries 0=CPU, 1=PCM, 2=PCM prefetch; one outstanding bus transaction.
    logic        mv [3];
    logic [15:0] mt [3];
    logic [7:0]  md [3];
    bit          m_busy;
    int          m_age;
    int          m_tgt;
    logic [15:0] m_cap;
    logic [16:0] m_addr;
    bit          m_last_cpu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0;
            mt[i] = 16'h0;
            md[i] = 8'h0;
        end
        m_busy     = 1'b0;
        m_age      = 0;
        m_tgt      = 0;
        m_cap      = 16'h0;
        m_addr     = 17'h0;
        m_last_cpu = 1'b0;
    endtask

    task automatic start_txn(input int tgt, input logic [15:0] tag, input logic [16:0] addr,
                             input bit is_cpu);
        m_busy     = 1'b1;
        m_age      = 0;
        m_tgt      = tgt;
        m_cap      = tag;
        m_addr     = addr;
        m_last_cpu = is_cpu;
    endtask

    // Compare this cycle's outputs, then advance the model over the coming clock edge.
    task automatic model_step();
        logic        ch, ph, nh, cm, pm, fp, fn, was_busy, pv, nv;
        logic [15:0] pt, ntg, nx;
        logic [7:0]  pd, nd;
        pv = mv[1]; pt = mt[1]; pd = md[1];
        nv = mv[2]; ntg = mt[2]; nd = md[2];
        ch = cpu_cs & mv[0] & (mt[0] == cpu_addr);
        ph = pcm_cs & pv & (pt == pcm_addr);
        nh = pcm_cs & nv & (ntg == pcm_addr);
        chk("cpu_ok", 32'(cpu_ok), 32'(ch));
        chk("cpu_data", 32'(cpu_data), 32'(md[0]));
        chk("pcm_ok", 32'(pcm_ok), 32'(ph | nh));
        chk("pcm_data", 32'(pcm_data), 32'(ph ? pd : (nh ? nd : pd)));
        chk("rom_cs", 32'(rom_cs), 32'(m_busy));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));

        cm = cpu_cs & ~ch;
        pm = pcm_cs & ~(ph | nh);
        fp = 1'b0;
        fn = 1'b0;
        was_busy = m_busy;
        if (m_busy) begin
            if (m_age >= 1 && rom_ok) begin
                mv[m_tgt] = 1'b1;
                mt[m_tgt] = m_cap;
                md[m_tgt] = rom_f(m_addr);
                fp = (m_tgt == 1);
                fn = (m_tgt == 2);
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end
        if (nh && !ph && !fp && !fn) begin
            mv[1] = 1'b1; mt[1] = ntg; md[1] = nd;
            mv[2] = 1'b0;
        end
        if (!was_busy) begin
            nx = pt + 16'd1;
            if (cm && (!pm || !m_last_cpu))
                start_txn(0, cpu_addr, {1'b0, cpu_addr}, 1'b1);
            else if (pm)
                start_txn(1, pcm_addr, 17'h10000 + {1'b0, pcm_addr}, 1'b0);
            else if (pcm_cs && pv && !(nv && ntg == nx) && pt != 16'hFFFF)
                start_txn(2, nx, 17'h10000 + {1'b0, nx}, 1'b0);
        end
    endtask

    // One clock: drive inputs at the falling edge, check 1 time unit later.
    task automatic step(input logic ccs, input logic [15:0] ca, input logic pcs,
                        input logic [15:0] pa, input logic ok);
        @(negedge clk);
        cpu_cs = ccs; cpu_addr = ca; pcm_cs = pcs; pcm_addr = pa; rom_ok = ok;
        #1;
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        cpu_cs = 1'b0; pcm_cs = 1'b0; rom_ok = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic        ccs, pcs, ok;
        logic [15:0] ca, pa;

        // Reset state
        do_reset();
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("rst_rom_cs", 32'(rom_cs), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_pcm_data", 32'(pcm_data), 32'h0);

        // CPU miss, rom_ok two cycles after rom_cs, then a cached re-read
        do_reset();
        step(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
        chk("t1_c0_ok", 32'(cpu_ok), 32'h0);
        step(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
        chk("t1_c1_cs", 32'(rom_cs), 32'h1);
        chk("t1_c1_addr", 32'(rom_addr), 32'h01234);
        step(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
        chk("t1_c4_ok", 32'(cpu_ok), 32'h1);
        chk("t1_c4_data", 32'(cpu_data), 32'(rom_f(17'h01234)));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
            chk("t1_reread_cs", 32'(rom_cs), 32'h0);
        end

        // Simultaneous misses after reset: CPU first, gap, then PCM
        do_reset();
        step(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
        step(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
        chk("t2_cpu_addr", 32'(rom_addr), 32'h00100);
        step(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b1);
        step(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
        chk("t2_gap_cs", 32'(rom_cs), 32'h0);
        chk("t2_cpu_ok", 32'(cpu_ok), 32'h1);
        step(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
        chk("t2_pcm_cs", 32'(rom_cs), 32'h1);
        chk("t2_pcm_addr", 32'(rom_addr), 32'h10200);
        step(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b1);
        step(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
        chk("t2_pcm_data", 32'(pcm_data), 32'(rom_f(17'h10200)));

        // PCM hit at 0x0040 triggers prefetch of 0x10041; advance hits N and promotes it
        do_reset();
        step(1'b0, 16'h0, 1'b1, 16'h0040, 1'b0);
        step(1'b0, 16'h0, 1'b1, 16'h0040, 1'b0);
        step(1'b0, 16'h0, 1'b1, 16'h0040, 1'b1);
        step(1'b0, 16'h0, 1'b1, 16'h0040, 1'b0);
        chk("t3_hit40", 32'(pcm_ok), 32'h1);
        step(1'b0, 16'h0, 1'b1, 16'h0040, 1'b0);
        chk("t3_pre_cs", 32'(rom_cs), 32'h1);
        chk("t3_pre_addr", 32'(rom_addr), 32'h10041);
        step(1'b0, 16'h0, 1'b1, 16'h0040, 1'b1);
        step(1'b0, 16'h0, 1'b1, 16'h0041, 1'b0);
        chk("t3_adv_ok", 32'(pcm_ok), 32'h1);
        chk("t3_adv_data", 32'(pcm_data), 32'(rom_f(17'h10041)));
        step(1'b0, 16'h0, 1'b1, 16'h0041, 1'b0);
        chk("t3_promo_cs", 32'(rom_cs), 32'h0);
        step(1'b0, 16'h0, 1'b1, 16'h0041, 1'b0);
        chk("t3_next_pre", 32'(rom_addr), 32'h10042);
        step(1'b0, 16'h0, 1'b1, 16'h0041, 1'b1);

        // No prefetch past 0xFFFF
        do_reset();
        step(1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b0);
        chk("t4_addr", 32'(rom_addr), 32'h1FFFF);
        step(1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b0);
            chk("t4_no_pre", 32'(rom_cs), 32'h0);
        end

        // CPU address changes while its fill is pending
        do_reset();
        step(1'b1, 16'h0010, 1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h0010, 1'b0, 16'h0, 1'b0);
        chk("t5_addr10", 32'(rom_addr), 32'h00010);
        step(1'b1, 16'h0020, 1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h0020, 1'b0, 16'h0, 1'b0);
        chk("t5_stale_ok", 32'(cpu_ok), 32'h0);
        step(1'b1, 16'h0020, 1'b0, 16'h0, 1'b0);
        chk("t5_addr20", 32'(rom_addr), 32'h00020);
        step(1'b1, 16'h0020, 1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h0020, 1'b0, 16'h0, 1'b0);
        chk("t5_ok20", 32'(cpu_ok), 32'h1);

        // Asynchronous reset mid-transaction, then a late rom_ok
        do_reset();
        step(1'b1, 16'h0300, 1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h0300, 1'b0, 16'h0, 1'b0);
        chk("t6_pre_rst_cs", 32'(rom_cs), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_cs", 32'(rom_cs), 32'h0);
        model_reset();
        @(negedge clk);
        cpu_cs = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0300, 1'b0, 16'h0, 1'b1);
            chk("t6_late_ok_cs", 32'(rom_cs), 32'h0);
        end

        // Randomized traffic against the model
        do_reset();
        ca = 16'h0;
        pa = 16'h0;
        for (int i = 0; i < 4000; i++) begin
            ccs = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0)
                ca = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
            pcs = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 5))
                0, 1:    pa = pa + 16'd1;
                2:       pa = 16'($urandom_range(0, 15));
                3:       pa = 16'hFFFE + 16'($urandom_range(0, 1));
                default: pa = pa;
            endcase
            ok = ($urandom_range(0, 2) == 0);
            step(ccs, ca, pcs, pa, ok);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
